// File: rtl/mbist_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : mbist_mem_if
//  Description : Port bundle between the MBIST controller and the synchronous
//                single-port memory.
//                  mem_en    - access enable
//                  mem_we    - 1 = write, 0 = read
//                  mem_addr  - word address
//                  mem_wdata - write data
//                  mem_rdata - read data, valid the cycle after a read issue
//                master modport: the controller; slave modport: the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mbist_mem_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mbist_march_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mbist_march_ctrl
//  Description : March C- memory BIST engine for a synchronous single-port
//                memory. Sequence:
//                  M0 up (w0), M1 up (r0,w1), M2 up (r1,w0),
//                  M3 down (r0,w1), M4 down (r1,w0), M5 up (r0)
//                Every read is compared one cycle later against the expected
//                background; mismatches pulse fail_pulse, bump a saturating
//                counter and latch the first failing address.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - begin a test (only honoured in IDLE)
//                mem             - memory bus (mbist_mem_if.master)
//                busy            - first op cycle through the flush cycle
//                done            - one-cycle end-of-test pulse
//                pass            - result, valid from done until next start
//                fail_pulse      - one-cycle pulse per read mismatch
//                first_fail_addr - address of the first mismatch
//                fail_count      - saturating mismatch count
//                MEM_SIZE must be >= 2 and <= 2**ADDR_WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module mbist_march_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 256,
    parameter int FCNT_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start,
    mbist_mem_if.master                mem,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail_pulse,
    output logic [ADDR_WIDTH-1:0]      first_fail_addr,
    output logic [FCNT_WIDTH-1:0]      fail_count
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [2:0]            c_ELEM_LAST = 3'd5;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [FCNT_WIDTH-1:0] c_FCNT_MAX  = '1;

    // Sequencer state
    logic [1:0]            r_state, w_state_nxt;
    logic [2:0]            r_elem,  w_elem_nxt;
    logic                  r_phase, w_phase_nxt;   // 0 = read half, 1 = write half
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_nxt;

    // Compare pipeline and results
    logic                  r_cmp_valid;
    logic [DATA_WIDTH-1:0] r_cmp_exp;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic                  r_fail_pulse;
    logic [FCNT_WIDTH-1:0] r_fail_count;
    logic [ADDR_WIDTH-1:0] r_first_fail_addr;
    logic                  r_pass;

    // Element decode
    logic w_two_op;     // element is a read/write pair
    logic w_desc;       // element walks addresses downwards
    logic w_rd_ones;    // read expects all-ones background
    logic w_wr_ones;    // write stores all-ones background
    logic w_is_read;
    logic w_addr_done;  // current op is the last one at this address
    logic w_addr_end;   // current address is the last of the element
    logic w_mismatch;

    always_comb begin
        w_two_op    = (r_elem >= 3'd1) && (r_elem <= 3'd4);
        w_desc      = (r_elem == 3'd3) || (r_elem == 3'd4);
        w_rd_ones   = (r_elem == 3'd2) || (r_elem == 3'd4);
        w_wr_ones   = (r_elem == 3'd1) || (r_elem == 3'd3);
        w_is_read   = (w_two_op && !r_phase) || (r_elem == c_ELEM_LAST);
        w_addr_done = !(w_two_op && !r_phase);
        w_addr_end  = w_desc ? (r_addr == '0) : (r_addr == c_ADDR_LAST);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_elem  <= 3'd0;
            r_phase <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
            r_phase <= w_phase_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_phase_nxt = r_phase;
        w_addr_nxt  = r_addr;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_RUN;
                    w_elem_nxt  = 3'd0;
                    w_phase_nxt = 1'b0;
                    w_addr_nxt  = '0;
                end
            end
            c_ST_RUN: begin
                if (!w_addr_done) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if (w_addr_end) begin
                        if (r_elem == c_ELEM_LAST) begin
                            w_state_nxt = c_ST_FLUSH;
                        end else begin
                            w_elem_nxt = r_elem + 3'd1;
                            // M3 and M4 start at the top of memory
                            w_addr_nxt = ((r_elem == 3'd2) || (r_elem == 3'd3)) ?
                                         c_ADDR_LAST : '0;
                        end
                    end else begin
                        w_addr_nxt = w_desc ? (r_addr - 1'b1) : (r_addr + 1'b1);
                    end
                end
            end
            c_ST_FLUSH: w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem.mem_en    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                mem.mem_en    = 1'b1;
                mem.mem_we    = !w_is_read;
                mem.mem_addr  = r_addr;
                mem.mem_wdata = (!w_is_read && w_wr_ones) ? '1 : '0;
                busy          = 1'b1;
            end
            c_ST_FLUSH: busy = 1'b1;
            c_ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Read compare pipeline and result registers
    // ------------------------------------------------------------------
    assign w_mismatch = r_cmp_valid && (mem.mem_rdata != r_cmp_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_valid       <= 1'b0;
            r_cmp_exp         <= '0;
            r_cmp_addr        <= '0;
            r_fail_pulse      <= 1'b0;
            r_fail_count      <= '0;
            r_first_fail_addr <= '0;
            r_pass            <= 1'b0;
        end else begin
            r_cmp_valid  <= (r_state == c_ST_RUN) && w_is_read;
            r_cmp_exp    <= w_rd_ones ? '1 : '0;
            r_cmp_addr   <= r_addr;
            r_fail_pulse <= w_mismatch;

            if ((r_state == c_ST_IDLE) && start) begin
                r_fail_count      <= '0;
                r_first_fail_addr <= '0;
                r_pass            <= 1'b0;
            end else if (w_mismatch) begin
                if (r_fail_count != c_FCNT_MAX) begin
                    r_fail_count <= r_fail_count + 1'b1;
                end
                // The counter never wraps to zero, so zero means "first".
                if (r_fail_count == '0) begin
                    r_first_fail_addr <= r_cmp_addr;
                end
            end

            // The last compare resolves in FLUSH; fold it into the verdict.
            if (r_state == c_ST_FLUSH) begin
                r_pass <= (r_fail_count == '0) && !w_mismatch;
            end
        end
    end

    assign fail_pulse      = r_fail_pulse;
    assign fail_count      = r_fail_count;
    assign first_fail_addr = r_first_fail_addr;
    assign pass            = r_pass;

endmodule
`default_nettype wire
